spi_flash_arb: RTL and testbench
================================

SPI_FLASH_ARB -- requirements
Module: spi_flash_arb

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning the SPI clock half-period in clock cycles (legal range 1..255).
REQ-002 SHALL have port clock  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  read request from requester 0/1.
REQ-005 SHALL have ports req0_addr/req1_addr  input  24  flash byte address.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1  request accepted this cycle.
REQ-007 SHALL have ports rsp0_valid/rsp1_valid  output  1  single-cycle read-data strobe.
REQ-008 SHALL have ports rsp0_data/rsp1_data  output  32  read word, valid while rspN_valid is high.
REQ-009 SHALL have ports spi_csb, spi_clk, spi_mosi  output  1  flash chip select (low active), clock, serial data out.
REQ-010 SHALL have port spi_miso  input  1  flash serial data in.
REQ-011 SHALL treat one clock and a synchronous, active-high reset as already decided; no other clock or reset exists.

Function
REQ-012 SHALL implement states IDLE, CMD, ADDR, DATA, GAP (plus DUMMY when configured).
REQ-013 SHALL assert reqN_ready only in IDLE, in the same cycle as the accepted reqN_valid; the handshake is reqN_valid and reqN_ready both high.
REQ-014 SHALL arbitrate round-robin: if one requester is valid it wins; if both are valid the requester not granted last wins; after reset requester 0 has priority.
REQ-015 SHALL latch the address at the handshake; address changes while valid and not ready are permitted and ignored until acceptance.
REQ-016 SHALL drive spi_csb low starting the cycle after the handshake and hold it low until the final data bit has been sampled.
REQ-017 SHALL use SPI mode 0: spi_clk idles low; spi_mosi changes after the falling edge; spi_miso is sampled on the rising edge; each half-period lasts CLK_DIV cycles.
REQ-018 SHALL send command 0x03 MSB first, then address bits 23..0, then clock in 32 data bits.
REQ-019 SHALL assemble the data little-endian: the first byte received goes to data[7:0] and the fourth to data[31:24], each byte MSB first.
REQ-020 SHALL pulse rspN_valid for exactly one cycle to the granted requester only, one cycle after the last rising-edge sample; rspN_data holds its value until the next response to that requester.
REQ-021 SHALL enter GAP after each transfer with spi_csb high for 2*CLK_DIV cycles before returning to IDLE; no request is accepted during GAP.
REQ-022 SHALL apply no back-pressure on responses; requesters must accept a strobe on any cycle.
REQ-023 SHALL hold spi_mosi low whenever spi_csb is high.

Reset
REQ-024 SHALL, on reset, force state IDLE, spi_csb=1, spi_clk=0, spi_mosi=0, req*_ready=0, rsp*_valid=0, rsp*_data=0, and priority to requester 0.
REQ-025 SHALL abort any in-flight transfer on reset mid-operation: spi_csb is high the cycle after reset is sampled, and no response is issued for the aborted request.

Configuration
REQ-026 SHALL, with SPI_FLASH_ARB_FAST_READ_EN defined, send command 0x0B and 8 dummy SPI clocks in DUMMY state (mosi low) between ADDR and DATA.
REQ-027 SHALL, without SPI_FLASH_ARB_FAST_READ_EN, send command 0x03 and have no DUMMY state.

Structure
REQ-028 SHALL place the state enum, command constants (0x03, 0x0B) and bit-count constants (8, 24, 32, 8 dummy) in the shared package spi_flash_arb_pkg.
REQ-029 SHALL split the SPI clock/bit-timing generator into the sub-module spi_flash_arb_clkgen, which produces rise/fall tick strobes from CLK_DIV.

Verification
REQ-030 SHALL check a single read: CLK_DIV=2, req0 addr 0x000100, flash bytes 11 22 33 44 -> rsp0_data=0x44332211, one rsp0_valid pulse, MOSI stream 0x03 then 0x000100.
REQ-031 SHALL check contention: req0 and req1 valid in the same cycle after reset -> req0 is served first then req1, with rsp strobes in that order and no crosstalk.
REQ-032 SHALL check fairness: both requesters held valid for 4 transfers -> grants alternate 0,1,0,1.
REQ-033 SHALL check reset mid-transfer: assert reset during ADDR -> spi_csb=1 the next cycle, no rsp strobe, and a following req1 read completes correctly.
REQ-034 SHALL check timing at CLK_DIV=1: spi_clk period is 2 cycles, CSB-low span is 128 cycles, GAP is 2 cycles.
REQ-035 SHALL check fast read with SPI_FLASH_ARB_FAST_READ_EN: MOSI shows 0x0B, addr, then 8 dummy clocks; data is correct and the CSB-low span is 144*CLK_DIV cycles.

Source files
------------

// File: rtl/spi_flash_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_arb_pkg
// Purpose  : Shared types and constants for the two-requester SPI flash read
//            arbiter: FSM state encoding, flash command opcodes, bit counts
//            of each transfer phase and a byte-order helper.
// Ports    : none (package)
// Config   : SPI_FLASH_ARB_FAST_READ_EN adds the DUMMY state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package spi_flash_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_GAP   = 3'd4
`ifdef SPI_FLASH_ARB_FAST_READ_EN
    ,
    ST_DUMMY = 3'd5
`endif
  } state_t;

  localparam logic [7:0] c_CMD_READ      = 8'h03;
  localparam logic [7:0] c_CMD_FAST_READ = 8'h0B;

  localparam int c_CMD_BITS   = 8;
  localparam int c_ADDR_BITS  = 24;
  localparam int c_DATA_BITS  = 32;
  localparam int c_DUMMY_BITS = 8;

  // Bytes arrive first-byte-first into the MSBs of the shift register;
  // the response word places the first byte in [7:0].
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_flash_arb_clkgen.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_arb_clkgen
// Purpose  : SPI clock / bit-timing generator. While enabled it alternates a
//            low and a high half-period of CLK_DIV cycles each and flags the
//            last cycle of each half so the caller can act on the edge.
// Ports    : clock  - system clock
//            reset  - synchronous active-high reset
//            en     - run the SPI clock (low while deasserted)
//            rise   - strobe: spi_clk goes high on the next clock edge
//            fall   - strobe: spi_clk goes low on the next clock edge
//            sclk   - SPI clock level (mode 0, idles low)
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_arb_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic rise,
  output logic fall,
  output logic sclk
);

  localparam logic [7:0] c_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;
  logic       r_phase;
  logic       w_wrap;

  assign w_wrap = (r_cnt == c_LAST);

  always_ff @(posedge clock) begin
    if (reset || !en) begin
      r_cnt   <= 8'd0;
      r_phase <= 1'b0;
    end else if (w_wrap) begin
      r_cnt   <= 8'd0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 8'd1;
    end
  end

  assign rise = en && w_wrap && !r_phase;
  assign fall = en && w_wrap && r_phase;
  assign sclk = r_phase;

endmodule
`default_nettype wire

// File: rtl/spi_flash_arb.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_arb
// Purpose  : Round-robin arbiter giving two requesters 32-bit read access to
//            a serial SPI flash (mode 0). Sends READ (0x03) + 24-bit address,
//            clocks in 4 bytes, returns them little-endian, then keeps chip
//            select high for 2*CLK_DIV cycles before the next request.
// Ports    : clock, reset            - system clock, sync active-high reset
//            reqN_valid/addr/ready   - request handshake, N = 0,1
//            rspN_valid/data         - one-cycle response strobe and word
//            spi_csb/clk/mosi/miso   - flash serial interface
// Config   : define SPI_FLASH_ARB_FAST_READ_EN to use FAST READ (0x0B) with
//            8 dummy clocks between address and data.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_arb
  import spi_flash_arb_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [23:0] req0_addr,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [23:0] req1_addr,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic        spi_csb,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

`ifdef SPI_FLASH_ARB_FAST_READ_EN
  localparam logic [7:0] c_CMD = c_CMD_FAST_READ;
`else
  localparam logic [7:0] c_CMD = c_CMD_READ;
`endif
  localparam logic [8:0] c_GAP_LAST = 9'(2 * CLK_DIV - 1);

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_bit_cnt;
  logic [8:0]  r_gap_cnt;
  logic [31:0] r_tx;
  logic [31:0] r_rx;
  logic        r_prio1;
  logic        r_owner;
  logic        r_done;

  logic        w_pick1;
  logic        w_accept;
  logic        w_shift_en;
  logic [4:0]  w_last_idx;
  logic        w_last;
  logic        w_rise;
  logic        w_fall;

  // Requester 1 wins when it is alone or when it holds priority.
  assign w_pick1  = req1_valid && (!req0_valid || r_prio1);
  assign w_accept = (r_state == ST_IDLE) && !reset && (req0_valid || req1_valid);
  assign w_last   = (r_bit_cnt == w_last_idx);

  spi_flash_arb_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clock (clock),
    .reset (reset),
    .en    (w_shift_en),
    .rise  (w_rise),
    .fall  (w_fall),
    .sclk  (spi_clk)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: every shifting phase ends on the falling edge of its
  // last bit, so the next phase starts with spi_clk low.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)         w_next = ST_CMD;
      ST_CMD:  if (w_fall && w_last) w_next = ST_ADDR;
`ifdef SPI_FLASH_ARB_FAST_READ_EN
      ST_ADDR:  if (w_fall && w_last) w_next = ST_DUMMY;
      ST_DUMMY: if (w_fall && w_last) w_next = ST_DATA;
`else
      ST_ADDR:  if (w_fall && w_last) w_next = ST_DATA;
`endif
      ST_DATA: if (w_fall && w_last) w_next = ST_GAP;
      ST_GAP:  if (r_gap_cnt == c_GAP_LAST) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_shift_en = 1'b0;
    w_last_idx = 5'd0;
    spi_csb    = 1'b1;
    req0_ready = w_accept && !w_pick1;
    req1_ready = w_accept && w_pick1;
    case (r_state)
      ST_CMD: begin
        w_shift_en = 1'b1;
        spi_csb    = 1'b0;
        w_last_idx = 5'(c_CMD_BITS - 1);
      end
      ST_ADDR: begin
        w_shift_en = 1'b1;
        spi_csb    = 1'b0;
        w_last_idx = 5'(c_ADDR_BITS - 1);
      end
`ifdef SPI_FLASH_ARB_FAST_READ_EN
      ST_DUMMY: begin
        w_shift_en = 1'b1;
        spi_csb    = 1'b0;
        w_last_idx = 5'(c_DUMMY_BITS - 1);
      end
`endif
      ST_DATA: begin
        w_shift_en = 1'b1;
        spi_csb    = 1'b0;
        w_last_idx = 5'(c_DATA_BITS - 1);
      end
      default: begin
        w_shift_en = 1'b0;
      end
    endcase
  end

  // Datapath. The transmit register holds {command, address}; it shifts in
  // zeros, so MOSI is low through DUMMY, DATA and whenever CSB is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bit_cnt  <= 5'd0;
      r_gap_cnt  <= 9'd0;
      r_tx       <= 32'd0;
      r_rx       <= 32'd0;
      r_prio1    <= 1'b0;
      r_owner    <= 1'b0;
      r_done     <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= 32'd0;
      rsp1_data  <= 32'd0;
    end else begin
      rsp0_valid <= r_done && !r_owner;
      rsp1_valid <= r_done && r_owner;
      if (r_done && !r_owner) rsp0_data <= byte_swap32(r_rx);
      if (r_done && r_owner)  rsp1_data <= byte_swap32(r_rx);

      r_done <= (r_state == ST_DATA) && w_rise && w_last;

      if (w_accept) begin
        r_tx      <= {c_CMD, w_pick1 ? req1_addr : req0_addr};
        r_owner   <= w_pick1;
        r_prio1   <= !w_pick1;
        r_bit_cnt <= 5'd0;
      end else if (w_shift_en && w_fall) begin
        r_tx      <= {r_tx[30:0], 1'b0};
        r_bit_cnt <= w_last ? 5'd0 : r_bit_cnt + 5'd1;
      end

      if ((r_state == ST_DATA) && w_rise) begin
        r_rx <= {r_rx[30:0], spi_miso};
      end

      r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + 9'd1 : 9'd0;
    end
  end

  assign spi_mosi = r_tx[31];

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_arb
// Purpose  : Directed self-checking bench for spi_flash_arb. One instance at
//            CLK_DIV=2 talks to a behavioural flash; a second at CLK_DIV=1
//            with MISO tied low is used for timing.
// Ports    : none
// Config   : honours SPI_FLASH_ARB_FAST_READ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_arb;

`ifdef SPI_FLASH_ARB_FAST_READ_EN
  localparam int         HB    = 40;
  localparam logic [7:0] CMD   = 8'h0B;
  localparam int         SPAN2 = 288;
  localparam int         SPAN1 = 144;
`else
  localparam int         HB    = 32;
  localparam logic [7:0] CMD   = 8'h03;
  localparam int         SPAN2 = 256;
  localparam int         SPAN1 = 128;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [23:0] req0_addr, req1_addr;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
  logic        spi_csb, spi_clk, spi_mosi;
  logic        spi_miso = 1'b0;

  logic        d1_req0_valid, d1_req0_ready, d1_req1_ready;
  logic [23:0] d1_req0_addr;
  logic        d1_rsp0_valid, d1_rsp1_valid;
  logic [31:0] d1_rsp0_data, d1_rsp1_data;
  logic        d1_csb, d1_sclk, d1_mosi;
  logic        d1_req1_valid = 1'b0;
  logic [23:0] d1_req1_addr  = 24'd0;
  logic        d1_miso       = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  spi_flash_arb #(.CLK_DIV(2)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .spi_csb(spi_csb), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_flash_arb #(.CLK_DIV(1)) dut1 (
    .clock(clock), .reset(reset),
    .req0_valid(d1_req0_valid), .req0_addr(d1_req0_addr), .req0_ready(d1_req0_ready),
    .req1_valid(d1_req1_valid), .req1_addr(d1_req1_addr), .req1_ready(d1_req1_ready),
    .rsp0_valid(d1_rsp0_valid), .rsp0_data(d1_rsp0_data),
    .rsp1_valid(d1_rsp1_valid), .rsp1_data(d1_rsp1_data),
    .spi_csb(d1_csb), .spi_clk(d1_sclk), .spi_mosi(d1_mosi), .spi_miso(d1_miso)
  );

  // Behavioural flash: captures MOSI on SPI rising edges, presents data on
  // falling edges. Address 0x000100 holds 11 22 33 44; any other address A
  // returns bytes A[7:0], A[15:8], A[23:16], 0x5C.
  int          fn = 0;
  logic [31:0] fhdr = 32'd0;
  logic        fdmy = 1'b0;
  logic [31:0] fstream = 32'd0;
  logic [31:0] last_hdr = 32'd0;
  logic        last_dmy = 1'b0;

  always @(negedge spi_csb) begin
    fn   = 0;
    fhdr = 32'd0;
    fdmy = 1'b0;
  end

  always @(posedge spi_csb) begin
    last_hdr = fhdr;
    last_dmy = fdmy;
  end

  always @(posedge spi_clk) begin
    if (spi_csb === 1'b0) begin
      if (fn < 32)      fhdr = {fhdr[30:0], spi_mosi};
      else if (fn < HB) fdmy = fdmy | spi_mosi;
      fn++;
    end
  end

  always @(negedge spi_clk) begin
    if (spi_csb === 1'b0) begin
      if (fn == HB)
        fstream = (fhdr[23:0] == 24'h000100) ? 32'h11223344
                                             : {fhdr[7:0], fhdr[15:8], fhdr[23:16], 8'h5C};
      if (fn >= HB && fn < HB + 32) spi_miso = fstream[31 - (fn - HB)];
      else                          spi_miso = 1'b0;
    end
  end

  // Mid-cycle monitors
  int cyc = 0;
  int rsp0_cnt = 0, rsp1_cnt = 0;
  int rsp_log[$];
  int csb_lo = 0, span = 0, idle_bad = 0;
  int d1_lo = 0, d1_span = 0, d1_hi = 0, d1_gap = -1, d1_hs = 0, d1_rsp = 0;
  int d1_period = 0, d1_last_rise = -1;
  bit d1_after = 1'b0;
  logic d1_sclk_prev = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (rsp0_valid === 1'b1) begin rsp0_cnt++; rsp_log.push_back(0); end
    if (rsp1_valid === 1'b1) begin rsp1_cnt++; rsp_log.push_back(1); end
    if (spi_csb === 1'b0) csb_lo++;
    else begin
      if (csb_lo != 0) span = csb_lo;
      csb_lo = 0;
    end
    if (spi_csb === 1'b1 && (spi_mosi !== 1'b0 || spi_clk !== 1'b0)) idle_bad++;

    if (d1_rsp0_valid === 1'b1) d1_rsp++;
    if (d1_req0_valid && d1_req0_ready === 1'b1) d1_hs++;
    if (d1_csb === 1'b0) begin
      d1_lo++;
      d1_hi    = 0;
      d1_after = 1'b1;
    end else begin
      if (d1_lo != 0) d1_span = d1_lo;
      d1_lo = 0;
      if (d1_req0_ready === 1'b1) begin
        if (d1_after) d1_gap = d1_hi;
        d1_after = 1'b0;
      end else begin
        d1_hi++;
      end
    end
    if (d1_sclk === 1'b1 && d1_sclk_prev === 1'b0) begin
      if (d1_last_rise >= 0) d1_period = cyc - d1_last_rise;
      d1_last_rise = cyc;
    end
    if (d1_csb !== 1'b0) d1_last_rise = -1;
    d1_sclk_prev = d1_sclk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic issue(input bit who, input logic [23:0] a);
    bit got = 1'b0;
    if (who) begin req1_valid = 1'b1; req1_addr = a; end
    else     begin req0_valid = 1'b1; req0_addr = a; end
    for (int k = 0; k < 2000 && !got; k++) begin
      #1;
      got = who ? req1_ready : req0_ready;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("handshake_done", {63'd0, got}, 64'd1);
  endtask

  task automatic wait_rsp(input int target);
    for (int k = 0; k < 3000 && (rsp0_cnt + rsp1_cnt) < target; k++) tick();
    chk("rsp_arrived", {63'd0, (rsp0_cnt + rsp1_cnt) >= target}, 64'd1);
  endtask

  int grants[$];

  task automatic run_both(input int n, input logic [23:0] a0, input logic [23:0] a1);
    int c = 0;
    req0_valid = 1'b1; req0_addr = a0;
    req1_valid = 1'b1; req1_addr = a1;
    for (int k = 0; k < 20000 && c < n; k++) begin
      #1;
      if (req0_valid && req0_ready) begin grants.push_back(0); c++; end
      else if (req1_valid && req1_ready) begin grants.push_back(1); c++; end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("grants_done", 64'(c), 64'(n));
  endtask

  initial begin
    int gb, lb, b0, b1, tot;
    int exp_g[4] = '{0, 1, 0, 1};
    reset = 1'b1;
    req0_valid = 1'b1; req0_addr = 24'd0;
    req1_valid = 1'b0; req1_addr = 24'd0;
    d1_req0_valid = 1'b0; d1_req0_addr = 24'd0;
    repeat (3) tick();

    // Reset state (req0_valid held high to show ready stays low in reset)
    chk("rst_csb", {63'd0, spi_csb}, 64'd1);
    chk("rst_sclk", {63'd0, spi_clk}, 64'd0);
    chk("rst_mosi", {63'd0, spi_mosi}, 64'd0);
    chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
    chk("rst_rsp_valid", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
    chk("rst_rsp_data", {rsp1_data, rsp0_data}, 64'd0);
    req0_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Single read
    issue(1'b0, 24'h000100);
    wait_rsp(1);
    repeat (10) tick();
    chk("single_data", 64'(rsp0_data), 64'h44332211);
    chk("single_rsp0_cnt", 64'(rsp0_cnt), 64'd1);
    chk("single_rsp1_cnt", 64'(rsp1_cnt), 64'd0);
    chk("single_mosi_hdr", 64'(last_hdr), {32'd0, CMD, 24'h000100});
    chk("single_dummy_low", {63'd0, last_dmy}, 64'd0);
    chk("single_csb_span", 64'(span), 64'(SPAN2));

    // Contention right after reset: req0 first, then req1
    reset = 1'b1; tick(); reset = 1'b0; tick();
    gb = grants.size(); lb = rsp_log.size(); tot = rsp0_cnt + rsp1_cnt;
    run_both(2, 24'h123456, 24'hABCDEF);
    wait_rsp(tot + 2);
    repeat (10) tick();
    chk("cont_grant0", 64'(grants[gb]), 64'd0);
    chk("cont_grant1", 64'(grants[gb + 1]), 64'd1);
    chk("cont_order0", 64'(rsp_log[lb]), 64'd0);
    chk("cont_order1", 64'(rsp_log[lb + 1]), 64'd1);
    chk("cont_data0", 64'(rsp0_data), 64'h5C123456);
    chk("cont_data1", 64'(rsp1_data), 64'h5CABCDEF);

    // Fairness: four back-to-back transfers alternate
    gb = grants.size(); b0 = rsp0_cnt; b1 = rsp1_cnt; tot = b0 + b1;
    run_both(4, 24'h000010, 24'h000020);
    wait_rsp(tot + 4);
    repeat (10) tick();
    for (int i = 0; i < 4; i++) chk($sformatf("fair_grant%0d", i), 64'(grants[gb + i]), 64'(exp_g[i]));
    chk("fair_rsp0_cnt", 64'(rsp0_cnt - b0), 64'd2);
    chk("fair_rsp1_cnt", 64'(rsp1_cnt - b1), 64'd2);
    chk("fair_data0", 64'(rsp0_data), 64'h5C000010);
    chk("fair_data1", 64'(rsp1_data), 64'h5C000020);

    // Reset during ADDR
    b0 = rsp0_cnt; b1 = rsp1_cnt;
    issue(1'b0, 24'h000200);
    repeat (40) tick();
    chk("abort_in_addr", {63'd0, (fn >= 8 && fn < 32)}, 64'd1);
    reset = 1'b1;
    tick();
    chk("abort_csb", {63'd0, spi_csb}, 64'd1);
    chk("abort_rsp0_data_cleared", 64'(rsp0_data), 64'd0);
    reset = 1'b0;
    repeat (300) tick();
    chk("abort_no_rsp", 64'(rsp0_cnt + rsp1_cnt), 64'(b0 + b1));
    issue(1'b1, 24'h00ABCD);
    wait_rsp(b0 + b1 + 1);
    repeat (10) tick();
    chk("after_abort_data1", 64'(rsp1_data), 64'h5C00ABCD);
    chk("after_abort_rsp0_cnt", 64'(rsp0_cnt), 64'(b0));

    // CLK_DIV=1 timing, two back-to-back transfers
    d1_req0_valid = 1'b1;
    for (int k = 0; k < 2000 && d1_hs < 2; k++) tick();
    d1_req0_valid = 1'b0;
    repeat (300) tick();
    chk("div1_handshakes", 64'(d1_hs), 64'd2);
    chk("div1_sclk_period", 64'(d1_period), 64'd2);
    chk("div1_csb_span", 64'(d1_span), 64'(SPAN1));
    chk("div1_gap", 64'(d1_gap), 64'd2);
    chk("div1_rsp_cnt", 64'(d1_rsp), 64'd2);

    chk("idle_lines_quiet", 64'(idle_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
